// File: rtl/ballot_controller.sv
// ---------------------------------------------------------------------------
// ballot_controller
//   Session sequencer for the voting machine. It opens and closes the poll and
//   arms one ballot for each poll-officer authorisation. It turns the candidate
//   vote pulses into a single one-hot grant, disarms an armed ballot after a
//   timeout, and steps the display through the candidates once the poll closes.
//
// Parameters
//   NUM_CAND     number of candidates (>=2)
//   CNT_W        width of total_votes, saturates at 2**CNT_W-1
//   ARM_TIMEOUT  cycles an armed ballot waits for a vote (>=2)
//   SHOW_CYCLES  cycles each candidate is shown in results mode (>=1)
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-low reset
//   open_poll     in   pulse: open the poll from IDLE
//   close_poll    in   pulse: close the poll (READY or ARMED)
//   officer_arm   in   pulse: authorise one ballot
//   vote_req      in   per-candidate vote pulses from the debouncers
//   vote_grant    out  one-hot accepted vote, one cycle
//   ballot_armed  out  high while a ballot awaits a vote
//   reject        out  pulse: multi-button press refused
//   timeout       out  pulse: armed ballot expired
//   results_mode  out  high once the poll is closed
//   disp_sel      out  candidate index shown in results mode
//   total_votes   out  ballots committed this session
//   full          out  total_votes saturated, arming refused
// ---------------------------------------------------------------------------
module ballot_controller #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int ARM_TIMEOUT = 1000,
  parameter int SHOW_CYCLES = 500
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        open_poll,
  input  logic                        close_poll,
  input  logic                        officer_arm,
  input  logic [NUM_CAND-1:0]         vote_req,
  output logic [NUM_CAND-1:0]         vote_grant,
  output logic                        ballot_armed,
  output logic                        reject,
  output logic                        timeout,
  output logic                        results_mode,
  output logic [$clog2(NUM_CAND)-1:0] disp_sel,
  output logic [CNT_W-1:0]            total_votes,
  output logic                        full
);

  localparam int SEL_W  = $clog2(NUM_CAND);
  localparam int TMR_W  = $clog2(ARM_TIMEOUT);
  localparam int SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(ARM_TIMEOUT - 1);
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_CAND - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    ARMED,
    COMMIT,
    CLOSED
  } state_t;

  state_t              state_reg, state_next;
  logic [TMR_W-1:0]    timer_reg, timer_next;
  logic [SHOW_W-1:0]   show_reg, show_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [NUM_CAND-1:0] grant_reg, grant_next;
  logic                reject_reg, reject_next;
  logic                timeout_reg, timeout_next;

  // Clearing the lowest set bit leaves something only if two or more bits
  // were set; a non-zero request without that residue is exactly one-hot.
  logic multi_vote;
  logic single_vote;
  assign multi_vote  = |(vote_req & (vote_req - 1'b1));
  assign single_vote = (vote_req != '0) && !multi_vote;

  logic full_int;
  assign full_int = (count_reg == CNT_MAX);

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    show_next    = '0;
    sel_next     = '0;
    count_next   = count_reg;
    grant_next   = '0;
    reject_next  = 1'b0;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (open_poll) state_next = READY;
      end

      READY: begin
        // Closing wins over a simultaneous arm request.
        if (close_poll) begin
          state_next = CLOSED;
        end else if (officer_arm && !full_int) begin
          state_next = ARMED;
          timer_next = TMR_LOAD;
        end
      end

      ARMED: begin
        if (close_poll) begin
          state_next = CLOSED;
          timer_next = '0;
        end else if (single_vote) begin
          // Grant and count are registered together so the logger sees the
          // grant in the same cycle total_votes reflects it.
          state_next = COMMIT;
          grant_next = vote_req;
          timer_next = '0;
          if (!full_int) count_next = count_reg + 1'b1;
        end else if (multi_vote) begin
          reject_next = 1'b1;
          timer_next  = TMR_LOAD;
        end else if (timer_reg == '0) begin
          state_next   = READY;
          timeout_next = 1'b1;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      COMMIT: begin
        state_next = READY;
      end

      CLOSED: begin
        // Terminal until reset; only the display rotation runs here.
        if (show_reg == SHOW_LAST) begin
          show_next = '0;
          sel_next  = (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;
        end else begin
          show_next = show_reg + 1'b1;
          sel_next  = sel_reg;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      show_reg    <= '0;
      sel_reg     <= '0;
      count_reg   <= '0;
      grant_reg   <= '0;
      reject_reg  <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      show_reg    <= show_next;
      sel_reg     <= sel_next;
      count_reg   <= count_next;
      grant_reg   <= grant_next;
      reject_reg  <= reject_next;
      timeout_reg <= timeout_next;
    end
  end

  assign vote_grant   = grant_reg;
  assign reject       = reject_reg;
  assign timeout      = timeout_reg;
  assign ballot_armed = (state_reg == ARMED);
  assign results_mode = (state_reg == CLOSED);
  assign disp_sel     = sel_reg;
  assign total_votes  = count_reg;
  assign full         = full_int;

endmodule
